// File: rtl/truth_table_pkg.sv
// -----------------------------------------------------------------------------
// truth_table_pkg
// Shared types and constants for the truth table sweeper.
//   state_t        : sweep controller states (IDLE, DRIVE, SAMPLE, DONE)
//   CODE_W         : width of the stimulus code {w,x,y,z}
//   RESULT_W       : width of one sampled result {f2,f3,f4,f7}
//   TIMER_W        : width of the settle down-counter
//   NUM_CODES      : number of codes in one sweep (and table entries)
//   golden_nibble  : extracts the expected result for a code from a packed
//                    64-bit golden table (nibble c at bits [4*c+3:4*c])
// -----------------------------------------------------------------------------
package truth_table_pkg;

  localparam int CODE_W    = 4;
  localparam int RESULT_W  = 4;
  localparam int TIMER_W   = 8;
  localparam int NUM_CODES = 1 << CODE_W;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    SAMPLE,
    DONE
  } state_t;

  function automatic logic [RESULT_W-1:0] golden_nibble(
    input logic [63:0]       golden,
    input logic [CODE_W-1:0] code
  );
    return golden[{code, 2'b00} +: RESULT_W];
  endfunction

endpackage

// File: rtl/truth_table_sweeper_settle_timer.sv
// -----------------------------------------------------------------------------
// settle_timer
// Loadable down-counter that measures how long each stimulus code is held.
// It stops at zero rather than wrapping, so the controller can sit on the
// zero flag for a cycle without the count running away.
// Ports:
//   clk, rst    : clock and asynchronous active-high reset (value -> 0)
//   load        : load load_value (has priority over dec)
//   load_value  : reload value
//   dec         : decrement by one when value is non-zero
//   value       : current count
//   zero        : high when value is zero
// -----------------------------------------------------------------------------
module settle_timer
  import truth_table_pkg::*;
#(
  parameter int W = TIMER_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         dec,
  output logic [W-1:0] value,
  output logic         zero
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= '0;
    end else if (load) begin
      value <= load_value;
    end else if (dec && (value != '0)) begin
      value <= value - 1'b1;
    end
  end

  assign zero = (value == '0);

endmodule

// File: rtl/truth_table_sweeper.sv
// -----------------------------------------------------------------------------
// truth_table_sweeper
// Stimulus and capture stage for the four-input breadboard logic block. A start
// pulse in IDLE sweeps codes 0..15 onto w,x,y,z, holds each one for
// SETTLE_CYCLES cycles, then samples the block outputs into a 16-entry table
// that can be read combinationally by code.
//
// Parameters:
//   SETTLE_CYCLES : cycles each code is held before sampling (1..255)
//   GOLDEN        : expected table for the optional check, nibble c = code c
//
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   start         : begin a sweep (only looked at in IDLE)
//   w, x, y, z    : stimulus bits, {w,x,y,z} == code
//   f_in          : breadboard outputs {f2,f3,f4,f7}
//   busy          : high while driving or sampling
//   done          : one-cycle pulse after code 15 is sampled
//   code          : current code under test
//   rd_addr       : table read address
//   rd_data       : table[rd_addr], combinational
//
// Optional build macro SWEEP_CHECK_EN adds:
//   mismatch_cnt  : number of samples differing from GOLDEN (saturates at 16)
//   pass          : set in the DONE cycle when no sample mismatched
// -----------------------------------------------------------------------------
module truth_table_sweeper
  import truth_table_pkg::*;
#(
  parameter int          SETTLE_CYCLES = 4,
  parameter logic [63:0] GOLDEN        = 64'h0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic                w,
  output logic                x,
  output logic                y,
  output logic                z,
  input  logic [RESULT_W-1:0] f_in,
  output logic                busy,
  output logic                done,
  output logic [CODE_W-1:0]   code,
  input  logic [CODE_W-1:0]   rd_addr,
  output logic [RESULT_W-1:0] rd_data
`ifdef SWEEP_CHECK_EN
  ,
  output logic [4:0]          mismatch_cnt,
  output logic                pass
`endif
);

  // A zero settle time would leave no DRIVE cycle at all, so reject it (and
  // anything that does not fit the 8-bit counter) at elaboration.
  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255) begin : g_bad_settle
    $error("truth_table_sweeper: SETTLE_CYCLES must be in 1..255");
  end

  localparam logic [TIMER_W-1:0] RELOAD = TIMER_W'(SETTLE_CYCLES - 1);
  localparam logic [CODE_W-1:0]  LAST_CODE = '1;

  state_t              state_q, state_d;
  logic [CODE_W-1:0]   code_q, code_d;
  logic [RESULT_W-1:0] result_tbl [NUM_CODES];

  logic                tmr_load;
  logic                tmr_dec;
  logic [TIMER_W-1:0]  tmr_value;
  logic                tmr_zero;
  logic                sample_en;

  settle_timer #(
    .W (TIMER_W)
  ) u_settle_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (tmr_load),
    .load_value (RELOAD),
    .dec        (tmr_dec),
    .value      (tmr_value),
    .zero       (tmr_zero)
  );

  // State, code and timer controls. The counter runs SETTLE_CYCLES-1 down to
  // 0 in DRIVE, which together with the SAMPLE cycle gives SETTLE_CYCLES+1
  // cycles per code.
  always_comb begin
    state_d   = state_q;
    code_d    = code_q;
    tmr_load  = 1'b0;
    tmr_dec   = 1'b0;
    sample_en = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = DRIVE;
          code_d   = '0;
          tmr_load = 1'b1;
        end
      end
      DRIVE: begin
        busy    = 1'b1;
        tmr_dec = (tmr_value != '0);
        if (tmr_zero) begin
          state_d = SAMPLE;
        end
      end
      SAMPLE: begin
        busy      = 1'b1;
        sample_en = 1'b1;
        if (code_q == LAST_CODE) begin
          state_d = DONE;
        end else begin
          code_d   = code_q + 1'b1;
          tmr_load = 1'b1;
          state_d  = DRIVE;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      code_q  <= '0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
    end
  end

  // Result table; reset clears it, start does not.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CODES; i++) begin
        result_tbl[i] <= '0;
      end
    end else if (sample_en) begin
      result_tbl[code_q] <= f_in;
    end
  end

  assign {w, x, y, z} = code_q;
  assign code         = code_q;
  assign rd_data      = result_tbl[rd_addr];

`ifdef SWEEP_CHECK_EN
  logic       accept;
  logic       miss;
  logic [4:0] mismatch_q, mismatch_next;
  logic       pass_q;

  assign accept = (state_q == IDLE) && start;

  // Count of samples that disagree with GOLDEN, including the one being
  // taken this cycle, so pass can be decided on the final SAMPLE edge.
  always_comb begin
    miss          = (f_in != golden_nibble(GOLDEN, code_q));
    mismatch_next = mismatch_q;
    if (sample_en && miss && (mismatch_q != 5'd16)) begin
      mismatch_next = mismatch_q + 5'd1;
    end
  end

  // pass is written on the edge into DONE so it is already valid while done
  // is high; it then holds until the next accepted start clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mismatch_q <= '0;
      pass_q     <= 1'b0;
    end else if (accept) begin
      mismatch_q <= '0;
      pass_q     <= 1'b0;
    end else begin
      mismatch_q <= mismatch_next;
      if (sample_en && (code_q == LAST_CODE)) begin
        pass_q <= (mismatch_next == 5'd0);
      end
    end
  end

  assign mismatch_cnt = mismatch_q;
  assign pass         = pass_q;
`endif

endmodule
